pipe_vect_hs: RTL
=================

Name: pipe_vect_hs

Overview:
- Elastic vector pipeline stage for the ASIP datapath.
- Sits between stages, e.g. decode->execute and execute->writeback.
- Carries one scalar control word plus NUM_VECT vector operands.
- Adds valid/ready back-pressure, synchronous flush, and a 2-entry skid buffer so a stall never drops data and full throughput is kept with a registered in_ready.

Parameters:
WIDTH, 8, scalar/control word width in bits
REGISTER_SIZE, 8, bits per vector lane
VECTOR_SIZE, 4, lanes per vector
NUM_VECT, 2, vector operands carried per transfer (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream has a transfer
in_ready  out  1  stage can accept a transfer
in  in  WIDTH  scalar word
vect_in  in  [NUM_VECT][VECTOR_SIZE][REGISTER_SIZE]  vector operands
out_valid  out  1  out/vect_out hold a valid transfer
out_ready  in  1  downstream accepts
out  out  WIDTH  scalar word
vect_out  out  [NUM_VECT][VECTOR_SIZE][REGISTER_SIZE]  vector operands

Behaviour:
- Reset (reset=0, async): out_valid=0, out=0, vect_out=0, skid register=0, skid_valid=0, state EMPTY. in_ready=1 (skid build) while reset is held.
- Handshakes: input fires when in_valid&in_ready; output fires when out_valid&out_ready. Payload is captured as one atomic word (in + all vect_in).
- Latency: 1 cycle from input fire to out_valid with the stage empty.
- Throughput: 1 transfer/cycle while out_ready=1.
- States (skid build):
  - EMPTY: main register invalid. in fire -> FULL.
  - FULL: main valid, skid empty.
    - in fire & out fire -> FULL, main<=in.
    - in fire & !out fire -> SKID, skid<=in.
    - out fire only -> EMPTY.
  - SKID: both valid. in_ready=0.
    - out fire -> FULL, main<=skid.
    - else hold.
- in_ready=!skid_valid, registered; no combinational path from out_ready.
- Ordering is strictly FIFO. The skid entry always drains before any new input.
- Stability: out/vect_out/out_valid do not change while out_valid=1 and out_ready=0, unless flush is asserted.
- Flush (priority over everything):
  - Next state is EMPTY. out_valid=0, skid_valid=0, payload registers zeroed.
  - Same-cycle input fire is discarded.
  - Same-cycle output fire counts as consumed.
- Reset mid-transfer: all entries are lost immediately. Nothing is emitted after reset release until a new input fire.
- Widths: pure transport, no arithmetic. Total payload is WIDTH+NUM_VECT*VECTOR_SIZE*REGISTER_SIZE bits.

Optional Feature:
PIPE_VECT_SKID_EN
- Defined: skid buffer and 3-state behaviour as above; in_ready is registered.
- Undefined: single register, no skid storage, states EMPTY/FULL only.
  - in_ready = !out_valid | out_ready, combinational.
  - With out_ready=0 and the stage full, in_ready=0.
  - Full throughput is still achieved when out_ready=1.
- Flush/reset semantics are identical in both builds.

Decomposition:
- pipe_vect_pkg holds:
  - typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_t
  - default constants PV_WIDTH=8, PV_REG_SIZE=8, PV_VECT_SIZE=4, PV_NUM_VECT=2
- One sub-module, pipe_vect_payload_reg: async active-low reset, synchronous clear, load-enable register for the packed payload.
  - Instantiated twice (main, skid).
  - The skid instance exists only under PIPE_VECT_SKID_EN.

Test Plan:
1. Reset then single transfer: in=8'hA5, vect_in[0]=32'h01020304, vect_in[1]=32'hF0E0D0C0, out_ready=1 -> out_valid=1 next cycle with identical payload; out_valid=0 after the fire.
2. Stream of 16 back-to-back transfers (in=0..15) with out_ready=1 -> 16 outputs on 16 consecutive cycles, in order; in_ready stays 1.
3. Back-pressure: out_ready=0 while sending 3 and 7.
   - SKID build: 3 held on out, 7 in skid, in_ready=0.
   - Release out_ready -> out 3 then 7, in_ready=1.
   - Non-skid build: in_ready=0 after 3.
4. Flush in SKID state with a new in_valid (in=9) -> out_valid=0 next cycle, in_ready=1, outputs zero; 9 never appears.
5. Assert reset (0) asynchronously mid-stream between clock edges -> out_valid, out, vect_out are 0 immediately; first output after release is the first post-reset input.
6. Parameter sweep NUM_VECT=1/3, VECTOR_SIZE=8, REGISTER_SIZE=16 with random valid/ready at 50% -> scoreboard shows no loss, no duplication, in-order delivery.

Source files
------------

// File: rtl/pipe_vect_pkg.sv
// Shared types and default sizing for the elastic vector pipeline stage.
// The PIPE_VECT_SKID_EN build uses all three states; the plain build uses EMPTY/FULL only.
package pipe_vect_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } pipe_state_t;

  localparam int PV_WIDTH     = 8;
  localparam int PV_REG_SIZE  = 8;
  localparam int PV_VECT_SIZE = 4;
  localparam int PV_NUM_VECT  = 2;

  function automatic int pv_payload_bits(input int width, input int num_vect,
                                         input int vect_size, input int reg_size);
    return width + num_vect * vect_size * reg_size;
  endfunction

endpackage

// File: rtl/pipe_vect_payload_reg.sv
// Load-enable payload register with async active-low reset and synchronous clear.
// Clear takes priority over load so a flush always leaves the register zeroed.
module pipe_vect_payload_reg #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            load,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_vect_hs.sv
// Elastic valid/ready stage carrying a scalar word plus NUM_VECT vector operands.
// Define PIPE_VECT_SKID_EN for the 2-entry skid build with a registered in_ready.
module pipe_vect_hs
  import pipe_vect_pkg::*;
#(
  parameter int WIDTH         = PV_WIDTH,
  parameter int REGISTER_SIZE = PV_REG_SIZE,
  parameter int VECTOR_SIZE   = PV_VECT_SIZE,
  parameter int NUM_VECT      = PV_NUM_VECT
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 flush,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [WIDTH-1:0]                                     in,
  input  logic [NUM_VECT-1:0][VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] vect_in,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [WIDTH-1:0]                                     out,
  output logic [NUM_VECT-1:0][VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] vect_out
);

  localparam int VBITS = NUM_VECT * VECTOR_SIZE * REGISTER_SIZE;
  localparam int PBITS = pv_payload_bits(WIDTH, NUM_VECT, VECTOR_SIZE, REGISTER_SIZE);

  pipe_state_t      state;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic [PBITS-1:0] in_word;
  logic [PBITS-1:0] main_d;
  logic [PBITS-1:0] main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign in_word  = {in, vect_in};
  assign out      = main_q[PBITS-1 -: WIDTH];
  assign vect_out = main_q[VBITS-1:0];

  pipe_vect_payload_reg #(.BITS(PBITS)) u_main (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

`ifdef PIPE_VECT_SKID_EN

  logic             skid_valid;
  logic             skid_load;
  logic             skid_clear;
  logic [PBITS-1:0] skid_q;

  // The main register refills from the skid entry first so ordering stays FIFO.
  assign main_load = ((state == EMPTY) && in_fire) ||
                     ((state == FULL) && in_fire && out_fire) ||
                     ((state == SKID) && out_fire);
  assign main_d     = (state == SKID) ? skid_q : in_word;
  assign skid_load  = (state == FULL) && in_fire && !out_fire;
  assign skid_clear = flush || ((state == SKID) && out_fire);

  pipe_vect_payload_reg #(.BITS(PBITS)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (skid_clear),
    .load  (skid_load),
    .d     (in_word),
    .q     (skid_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (in_fire && !out_fire) begin
            state      <= SKID;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
          end else if (!in_fire && out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        SKID: begin
          if (out_fire) begin
            state      <= FULL;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

`else

  // Without skid storage the stage can only accept when its word leaves this cycle.
  assign in_ready  = !out_valid | out_ready;
  assign main_load = in_fire;
  assign main_d    = in_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (out_fire && !in_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule
